// File: rtl/alu_cmd_sequencer.sv
// Command front end for the 32-bit combinational ALU: owns the register file, registers
// operands for the ALU, captures its result one cycle later, optionally writes it back and
// returns it over a valid/ready response channel.
module alu_cmd_sequencer #(
  parameter int unsigned RA_W  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic [RA_W-1:0]  ld_addr,
  input  logic [31:0]      ld_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [RA_W-1:0]  cmd_ra,
  input  logic [RA_W-1:0]  cmd_rb,
  input  logic [RA_W-1:0]  cmd_rd,
  input  logic             cmd_wb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_f,
  output logic             rsp_zf,
  output logic             rsp_of,
  output logic [31:0]      ALU_A,
  output logic [31:0]      ALU_B,
  output logic [2:0]       ALU_OP,
  input  logic [31:0]      ALU_F,
  input  logic             ALU_ZF,
  input  logic             ALU_OF,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned NumRegs = 2 ** RA_W;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [31:0]      rf_q [NumRegs];
  logic [31:0]      rf_d [NumRegs];
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic             wb_q, wb_d;
  logic [31:0]      rsp_f_q, rsp_f_d;
  logic             rsp_zf_q, rsp_zf_d;
  logic             rsp_of_q, rsp_of_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic cmd_accept;
  logic rsp_done;

  assign cmd_accept = (state_q == StIdle) && cmd_valid;
  assign rsp_done   = (state_q == StResp) && rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: EXEC is always a single cycle, RESP waits for the handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
  end

  // Datapath next state: register file, operand registers, response capture, counter.
  always_comb begin
    rf_d     = rf_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rd_d     = rd_q;
    wb_d     = wb_q;
    rsp_f_d  = rsp_f_q;
    rsp_zf_d = rsp_zf_q;
    rsp_of_d = rsp_of_q;
    cnt_d    = cnt_q;

    // Operands are read from rf_q, so a same-cycle load is not seen by the command.
    if (cmd_accept) begin
      alu_a_d  = rf_q[cmd_ra];
      alu_b_d  = rf_q[cmd_rb];
      alu_op_d = cmd_op;
      rd_d     = cmd_rd;
      wb_d     = cmd_wb;
    end

    if ((state_q == StIdle) && ld_en && (ld_addr != '0)) begin
      rf_d[ld_addr] = ld_data;
    end

    if (state_q == StExec) begin
      rsp_f_d  = ALU_F;
      rsp_zf_d = ALU_ZF;
      // OF is only meaningful for ADD/SUB; the ALU leaves it undefined otherwise.
      rsp_of_d = (alu_op_q == 3'b100 || alu_op_q == 3'b101) ? ALU_OF : 1'b0;
      if (wb_q && (rd_q != '0)) begin
        rf_d[rd_q] = ALU_F;
      end
    end

    if (rsp_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // r0 is hardwired to zero.
    rf_d[0] = '0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      rsp_f_q  <= '0;
      rsp_zf_q <= 1'b0;
      rsp_of_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rf_q     <= rf_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      rd_q     <= rd_d;
      wb_q     <= wb_d;
      rsp_f_q  <= rsp_f_d;
      rsp_zf_q <= rsp_zf_d;
      rsp_of_q <= rsp_of_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ALU_A    = alu_a_q;
  assign ALU_B    = alu_b_q;
  assign ALU_OP   = alu_op_q;
  assign rsp_f    = rsp_f_q;
  assign rsp_zf   = rsp_zf_q;
  assign rsp_of   = rsp_of_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU attached to its ALU port.
module tb_alu_cmd_sequencer;

  localparam int unsigned RA_W  = 3;
  // Narrow counter keeps the wrap from all-ones to zero reachable in a few dozen ops.
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             ld_en;
  logic [RA_W-1:0]  ld_addr;
  logic [31:0]      ld_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [RA_W-1:0]  cmd_ra;
  logic [RA_W-1:0]  cmd_rb;
  logic [RA_W-1:0]  cmd_rd;
  logic             cmd_wb;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_f;
  logic             rsp_zf;
  logic             rsp_of;
  logic [31:0]      ALU_A;
  logic [31:0]      ALU_B;
  logic [2:0]       ALU_OP;
  logic [31:0]      ALU_F;
  logic             ALU_ZF;
  logic             ALU_OF;
  logic [CNT_W-1:0] op_count;

  alu_cmd_sequencer #(
    .RA_W (RA_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_ra   (cmd_ra),
    .cmd_rb   (cmd_rb),
    .cmd_rd   (cmd_rd),
    .cmd_wb   (cmd_wb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_f    (rsp_f),
    .rsp_zf   (rsp_zf),
    .rsp_of   (rsp_of),
    .ALU_A    (ALU_A),
    .ALU_B    (ALU_B),
    .ALU_OP   (ALU_OP),
    .ALU_F    (ALU_F),
    .ALU_ZF   (ALU_ZF),
    .ALU_OF   (ALU_OF),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; OF is driven high for non-arithmetic ops to model its undefined value.
  always_comb begin
    logic [31:0] f;
    logic        of;
    f  = '0;
    of = 1'b1;
    case (ALU_OP)
      3'b000: f = ALU_A & ALU_B;
      3'b001: f = ALU_A | ALU_B;
      3'b010: f = ALU_A ^ ALU_B;
      3'b011: f = ~(ALU_A | ALU_B);
      3'b100: begin
        f  = ALU_A + ALU_B;
        of = (ALU_A[31] == ALU_B[31]) && (f[31] != ALU_A[31]);
      end
      3'b101: begin
        f  = ALU_A - ALU_B;
        of = (ALU_A[31] != ALU_B[31]) && (f[31] != ALU_A[31]);
      end
      3'b110: f = {31'b0, ALU_A < ALU_B};
      default: f = ALU_A << ALU_B[4:0];
    endcase
    ALU_F  = f;
    ALU_ZF = (f == 32'h0);
    ALU_OF = of;
  end

  typedef struct {
    string           name;
    logic [2:0]      op;
    logic [RA_W-1:0] ra;
    logic [RA_W-1:0] rb;
    logic [RA_W-1:0] rd;
    logic            wb;
    logic [31:0]     exp_f;
    logic            exp_zf;
    logic            exp_of;
  } vec_t;

  int unsigned      total;
  int unsigned      bad;
  logic [CNT_W-1:0] exp_cnt;
  vec_t             vecs[12];
  vec_t             v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load(input logic [RA_W-1:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Issue one command from IDLE and follow it through the fixed-latency pipeline.
  // Optional same-cycle load at accept, and optional response backpressure with a load
  // attempt to r6 during the stall.
  task automatic run_cmd(input vec_t c, input bit with_ld, input logic [RA_W-1:0] la,
                         input logic [31:0] ldat, input int hold);
    chk({c.name, " cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = c.op;
    cmd_ra    = c.ra;
    cmd_rb    = c.rb;
    cmd_rd    = c.rd;
    cmd_wb    = c.wb;
    if (with_ld) begin
      ld_en   = 1'b1;
      ld_addr = la;
      ld_data = ldat;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ld_en     = 1'b0;
    chk({c.name, " alu_op"}, {29'b0, ALU_OP}, {29'b0, c.op});
    chk({c.name, " exec rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({c.name, " exec cmd_ready"}, {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk({c.name, " rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({c.name, " rsp_f"}, rsp_f, c.exp_f);
    chk({c.name, " rsp_zf"}, {31'b0, rsp_zf}, {31'b0, c.exp_zf});
    chk({c.name, " rsp_of"}, {31'b0, rsp_of}, {31'b0, c.exp_of});
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        ld_en   = 1'b1;
        ld_addr = 3'd6;
        ld_data = 32'hDEADBEEF;
      end
      @(posedge clk); #1;
      ld_en = 1'b0;
      chk({c.name, " stall rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({c.name, " stall rsp_f"}, rsp_f, c.exp_f);
      chk({c.name, " stall cmd_ready"}, {31'b0, cmd_ready}, 32'd0);
      chk({c.name, " stall op_count"}, 32'(op_count), 32'(exp_cnt));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt   = exp_cnt + 1'b1;
    chk({c.name, " done rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({c.name, " done cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    chk({c.name, " op_count"}, 32'(op_count), 32'(exp_cnt));
  endtask

  function automatic vec_t mk(input string n, input logic [2:0] op, input int ra, input int rb,
                              input int rd, input logic wb, input logic [31:0] f,
                              input logic zf, input logic of);
    vec_t r;
    r.name   = n;
    r.op     = op;
    r.ra     = RA_W'(ra);
    r.rb     = RA_W'(rb);
    r.rd     = RA_W'(rd);
    r.wb     = wb;
    r.exp_f  = f;
    r.exp_zf = zf;
    r.exp_of = of;
    return r;
  endfunction

  initial begin
    total     = 0;
    bad       = 0;
    exp_cnt   = '0;
    rst_n     = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_ra    = '0;
    cmd_rb    = '0;
    cmd_rd    = '0;
    cmd_wb    = 1'b0;
    rsp_ready = 1'b0;

    vecs[0]  = mk("add_ovf",   3'b100, 1, 2, 3, 1'b1, 32'h80000000, 1'b0, 1'b1);
    vecs[1]  = mk("or_r3_r0",  3'b001, 3, 0, 0, 1'b0, 32'h80000000, 1'b0, 1'b0);
    vecs[2]  = mk("sub_zero",  3'b101, 2, 2, 4, 1'b1, 32'h00000000, 1'b1, 1'b0);
    vecs[3]  = mk("shl",       3'b111, 5, 2, 0, 1'b0, 32'h00000006, 1'b0, 1'b0);
    vecs[4]  = mk("ltu_true",  3'b110, 2, 5, 0, 1'b0, 32'h00000001, 1'b0, 1'b0);
    vecs[5]  = mk("ltu_false", 3'b110, 5, 2, 0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    vecs[6]  = mk("xor_mask",  3'b010, 1, 1, 0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    vecs[7]  = mk("add_to_r0", 3'b100, 5, 2, 0, 1'b1, 32'h00000004, 1'b0, 1'b0);
    vecs[8]  = mk("or_r0_r0",  3'b001, 0, 0, 0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    vecs[9]  = mk("and",       3'b000, 1, 3, 0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    vecs[10] = mk("nor_r4",    3'b011, 4, 4, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
    vecs[11] = mk("sub_ovf",   3'b101, 3, 2, 0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);

    #12;
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset op_count", 32'(op_count), 32'd0);
    chk("reset alu_a", ALU_A, 32'd0);
    chk("reset rsp_f", rsp_f, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset cmd_ready", {31'b0, cmd_ready}, 32'd1);

    load(3'd1, 32'h7FFFFFFF);
    load(3'd2, 32'h00000001);
    load(3'd5, 32'h00000003);
    load(3'd0, 32'hFFFFFFFF);

    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i], 1'b0, '0, '0, 0);
    end

    // Backpressure for five cycles with an ignored load to r6.
    run_cmd(mk("stall_add", 3'b100, 5, 2, 0, 1'b0, 32'h4, 1'b0, 1'b0), 1'b0, '0, '0, 5);
    run_cmd(mk("r6_unchanged", 3'b001, 6, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0), 1'b0, '0, '0, 0);

    // Load and command in the same cycle: command sees the old r1.
    run_cmd(mk("ld_same_cyc", 3'b001, 1, 0, 0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0),
            1'b1, 3'd1, 32'h12345678, 0);
    run_cmd(mk("ld_visible", 3'b001, 1, 0, 0, 1'b0, 32'h12345678, 1'b0, 1'b0),
            1'b0, '0, '0, 0);

    // Reset during EXEC of ADD with writeback to r7.
    cmd_valid = 1'b1;
    cmd_op    = 3'b100;
    cmd_ra    = 3'd1;
    cmd_rb    = 3'd2;
    cmd_rd    = 3'd7;
    cmd_wb    = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    exp_cnt = '0;
    chk("abort rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort op_count", 32'(op_count), 32'd0);
    chk("abort alu_b", ALU_B, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort cmd_ready", {31'b0, cmd_ready}, 32'd1);
    run_cmd(mk("r7_cleared", 3'b001, 7, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0), 1'b0, '0, '0, 0);
    run_cmd(mk("r1_cleared", 3'b001, 1, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0), 1'b0, '0, '0, 0);

    // Count up to all-ones, then one more op wraps to zero.
    while (exp_cnt != '1) begin
      run_cmd(mk("wrap_fill", 3'b000, 0, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0), 1'b0, '0, '0, 0);
    end
    chk("count all ones", 32'(op_count), 32'((1 << CNT_W) - 1));
    run_cmd(mk("wrap_last", 3'b000, 0, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0), 1'b0, '0, '0, 0);
    chk("count wrapped", 32'(op_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven front end for the 32-bit multifunction ALU. It owns an 8×32 register file, accepts ALU commands over a valid/ready handshake and drives the ALU's A/B/ALU_OP inputs from registered operands. It captures F/ZF/OF after one settle cycle, optionally writes F back to the register file, and returns the result over a valid/ready response channel. It sits between the host/control logic and the combinational ALU.

## Interface
- `RA_W`, default 3: register address width; register count is 2^RA_W.
- `CNT_W`, default 16: width of the completed-operation counter.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `ld_en`  in  1  host register load strobe
- `ld_addr`  in  RA_W  load target register
- `ld_data`  in  32  load value
- `cmd_valid`  in  1  command valid
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_op`  in  3  ALU opcode: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 unsigned A<B, 111 A<<B
- `cmd_ra`, `cmd_rb`  in  RA_W  operand register addresses
- `cmd_rd`  in  RA_W  writeback register address
- `cmd_wb`  in  1  writeback enable
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accepted
- `rsp_f`  out  32  captured result
- `rsp_zf`  out  1  captured zero flag
- `rsp_of`  out  1  captured overflow flag, masked
- `ALU_A`, `ALU_B`  out  32  registered ALU operands
- `ALU_OP`  out  3  registered ALU opcode
- `ALU_F`  in  32  ALU result
- `ALU_ZF`, `ALU_OF`  in  1  ALU flags
- `op_count`  out  CNT_W  completed response handshakes

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: `cmd_ready`=1. On `cmd_valid`: register `ALU_A`←reg[ra], `ALU_B`←reg[rb], `ALU_OP`←op; latch rd and wb; go to EXEC.
  - EXEC: lasts exactly one cycle. At its closing edge, capture `rsp_f`←`ALU_F` and `rsp_zf`←`ALU_ZF`. Capture `rsp_of`←`ALU_OF` only when op is 100 or 101; otherwise `rsp_of`←0, which masks the ALU's undefined OF. If wb=1 and rd≠0, write reg[rd]←`ALU_F` on the same edge. Go to RESP.
  - RESP: `rsp_valid`=1. Hold `rsp_*` stable until `rsp_ready`. On the handshake: `op_count`+1 (wraps from all-ones to 0), go to IDLE.
- `cmd_ready`=0 in EXEC and RESP; no command queuing.
- Register 0 always reads 0. Writes to it, by load or writeback, are discarded.
- `ld_en` is honoured only in IDLE and is silently ignored in EXEC and RESP.
- Load and command handshake in the same IDLE cycle: the command reads pre-load register values; the load takes effect at the same edge.
- Load to the same address as a command's ra/rb in that cycle: the command sees the old value.
- `ALU_A`/`ALU_B`/`ALU_OP` hold their last values outside EXEC and change only on command acceptance.

## Timing
- Reset (async assert, any state): state=IDLE; all registers=0; `ALU_A`=`ALU_B`=0; `ALU_OP`=000; `rsp_f`=0; `rsp_zf`=0; `rsp_of`=0; `rsp_valid`=0; `op_count`=0. `cmd_ready`=1 from the first cycle after deassertion.
- Reset mid-EXEC or mid-RESP aborts the operation: no writeback, no response, no count increment.
- Command accepted at edge N: ALU inputs valid after N; result captured and writeback at edge N+1; `rsp_valid`=1 from N+1.
- If `rsp_ready`=1 at edge N+2, the response completes there, `cmd_ready`=1 after N+2, and the next accept is at N+3 at earliest. Minimum issue interval is 3 cycles.
- A writeback at edge N+1 is visible to any command accepted at N+3 or later.
- `rsp_valid` never drops without a handshake; `rsp_f`/`rsp_zf`/`rsp_of` never change while `rsp_valid`=1.

## Test plan
- Load r1=0x7FFFFFFF and r2=0x00000001; ADD r1,r2→r3 with wb=1 → `rsp_f`=0x80000000, `zf`=0, `of`=1; a following OR r3,r0 returns 0x80000000.
- SUB r2,r2→r4 with wb=1 → `rsp_f`=0, `zf`=1, `of`=0. Then SHL with r5=0x3, r2=1 → `rsp_f`=0x6. Unsigned LT with r2=1, r5=3 → 1; swapped operands → 0 with `zf`=1.
- XOR r1,r1 (ALU OF stub forced to 1) → `rsp_f`=0, `zf`=1, `rsp_of`=0 (masked).
- ADD r5,r2→r0 with wb=1 → `rsp_f`=0x4. A subsequent OR r0,r0 → `rsp_f`=0, `zf`=1. A load to r0 of 0xFFFFFFFF has no effect.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid`, `rsp_f` stable; `cmd_ready`=0. An `ld_en` to r6 during this window is ignored (r6 reads 0 afterwards). `op_count` increments by exactly 1 at release.
- Assert `rst_n`=0 during EXEC of ADD with wb to r7 → r7=0, `rsp_valid`=0, `op_count`=0, `cmd_ready`=1 after release. Separately, preset `op_count` to 0xFFFF via 65535 ops then one more → 0x0000.
